// File: rtl/time_bcd_converter.sv
// Converts binary minutes/seconds to four BCD digits with a sequential double-dabble engine.
// Optional macro FINISH_BLINK_EN blanks the digits periodically while finish is high.
//
// state | meaning
// IDLE  | waiting for the inputs to differ from the last converted value
// SHIFT | one double-dabble step per cycle, minutes and seconds in parallel
// LOAD  | publish the scratch digits and pulse update
module time_bcd_converter #(
    parameter int         IN_WIDTH     = 6,
    parameter int         BLINK_PERIOD = 25000000,
    parameter logic [3:0] BLANK_CODE   = 4'hF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] inMinutes,
    input  logic [IN_WIDTH-1:0] inSeconds,
    input  logic                finish,
    output logic [3:0]          minTens,
    output logic [3:0]          minOnes,
    output logic [3:0]          secTens,
    output logic [3:0]          secOnes,
    output logic                valid,
    output logic                update,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t              state, state_next;
    logic                primed;
    logic                start;
    logic [IN_WIDTH-1:0] shadow_min, shadow_sec;
    logic [IN_WIDTH-1:0] shift_min, shift_sec;
    logic [7:0]          bcd_min, bcd_sec;
    logic [7:0]          adj_min, adj_sec;
    logic [2:0]          bit_cnt;
    logic [3:0]          min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;

    function automatic logic [7:0] add3(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b[3:0] >= 4'd5) r[3:0] = b[3:0] + 4'd3;
        if (b[7:4] >= 4'd5) r[7:4] = b[7:4] + 4'd3;
        return r;
    endfunction

    always_comb begin
        start      = !primed || ({inMinutes, inSeconds} != {shadow_min, shadow_sec});
        adj_min    = add3(bcd_min);
        adj_sec    = add3(bcd_sec);
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (bit_cnt == 3'd1) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Inputs are captured once per conversion; changes mid-run are picked up by the next IDLE compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            primed     <= 1'b0;
            shadow_min <= '0;
            shadow_sec <= '0;
            shift_min  <= '0;
            shift_sec  <= '0;
            bcd_min    <= '0;
            bcd_sec    <= '0;
            bit_cnt    <= '0;
            min_tens_q <= '0;
            min_ones_q <= '0;
            sec_tens_q <= '0;
            sec_ones_q <= '0;
            valid      <= 1'b0;
            update     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            update <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow_min <= inMinutes;
                        shadow_sec <= inSeconds;
                        shift_min  <= inMinutes;
                        shift_sec  <= inSeconds;
                        bcd_min    <= '0;
                        bcd_sec    <= '0;
                        bit_cnt    <= 3'(IN_WIDTH);
                        busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    bcd_min   <= {adj_min[6:0], shift_min[IN_WIDTH-1]};
                    bcd_sec   <= {adj_sec[6:0], shift_sec[IN_WIDTH-1]};
                    shift_min <= shift_min << 1;
                    shift_sec <= shift_sec << 1;
                    bit_cnt   <= bit_cnt - 3'd1;
                end
                LOAD: begin
                    min_tens_q <= bcd_min[7:4];
                    min_ones_q <= bcd_min[3:0];
                    sec_tens_q <= bcd_sec[7:4];
                    sec_ones_q <= bcd_sec[3:0];
                    primed     <= 1'b1;
                    valid      <= 1'b1;
                    update     <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef FINISH_BLINK_EN
    localparam int BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               blink_tc;

    // Down-counter reloads from zero, so the first toggle lands BLINK_PERIOD edges after finish rises.
    assign blink_tc = (BLINK_PERIOD == 1) || (blink_cnt == BLINK_W'(1));

    always_ff @(posedge clk) begin
        if (reset || !finish) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (blink_cnt == '0) blink_cnt <= BLINK_W'(BLINK_PERIOD - 1);
            else                 blink_cnt <= blink_cnt - BLINK_W'(1);
            if (blink_tc) blink_phase <= ~blink_phase;
        end
    end

    assign minTens = blink_phase ? BLANK_CODE : min_tens_q;
    assign minOnes = blink_phase ? BLANK_CODE : min_ones_q;
    assign secTens = blink_phase ? BLANK_CODE : sec_tens_q;
    assign secOnes = blink_phase ? BLANK_CODE : sec_ones_q;
`else
    logic [5:0] unused_blink_cfg;
    assign unused_blink_cfg = {finish, BLANK_CODE, (BLINK_PERIOD > 0)};

    assign minTens = min_tens_q;
    assign minOnes = min_ones_q;
    assign secTens = sec_tens_q;
    assign secOnes = sec_ones_q;
`endif

endmodule

// File: tb/tb_time_bcd_converter.sv
// Directed bench for time_bcd_converter; each task drives one scenario and checks inline.
module tb_time_bcd_converter;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] inMinutes, inSeconds;
    logic       finish;
    logic [3:0] minTens, minOnes, secTens, secOnes;
    logic       valid, update, busy;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    time_bcd_converter #(.IN_WIDTH(6), .BLINK_PERIOD(4), .BLANK_CODE(4'hF)) dut (
        .clk(clk), .reset(reset), .inMinutes(inMinutes), .inSeconds(inSeconds),
        .finish(finish), .minTens(minTens), .minOnes(minOnes), .secTens(secTens),
        .secOnes(secOnes), .valid(valid), .update(update), .busy(busy)
    );

    wire [15:0] digits = {minTens, minOnes, secTens, secOnes};

    task automatic test_reset();
        reset = 1'b1; inMinutes = 6'd0; inSeconds = 6'd0; finish = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({digits, valid, update, busy} !== 19'd0)
            $display("FAIL reset_state: got digits=%h v/u/b=%b%b%b want 0000 000", digits, valid, update, busy);
        else passed++;
    endtask

    task automatic test_first_conversion();
        int busy_ok = 1;
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || update !== 1'b0) busy_ok = 0;
        end
        total++;
        if (busy_ok == 0) $display("FAIL first_busy: busy not high for 7 cycles (busy=%b update=%b)", busy, update);
        else passed++;
        @(negedge clk);
        total++;
        if ({update, busy, valid, digits} !== {3'b101, 16'h0000})
            $display("FAIL first_load: got u/b/v=%b%b%b digits=%h want 101 0000", update, busy, valid, digits);
        else passed++;
        @(negedge clk);
        total++;
        if ({update, valid} !== 2'b01)
            $display("FAIL first_after: got update=%b valid=%b want 0 1", update, valid);
        else passed++;
    endtask

    task automatic test_convert_59();
        int pulses = 0;
        int pulse_at = -1;
        logic [15:0] seen = 16'h0;
        inMinutes = 6'd59; inSeconds = 6'd59;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (update) begin
                pulses++;
                if (pulse_at < 0) begin pulse_at = i; seen = digits; end
            end
        end
        total++;
        if (pulses != 1) $display("FAIL hold_59_pulses: got %0d update pulses want 1", pulses);
        else passed++;
        total++;
        if (pulse_at != 7) $display("FAIL hold_59_latency: got pulse at sample %0d want 7", pulse_at);
        else passed++;
        total++;
        if (seen !== 16'h5959) $display("FAIL hold_59_digits: got %h want 5959", seen);
        else passed++;
    endtask

    task automatic convert_and_check(input logic [5:0] m, input logic [5:0] s,
                                     input logic [15:0] want, input string name);
        int got = 0;
        inMinutes = m; inSeconds = s;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (update) got = 1;
        end
        total++;
        if (got == 0) $display("FAIL %s: no update within 20 cycles, digits=%h want %h", name, digits, want);
        else if (digits !== want) $display("FAIL %s: got %h want %h", name, digits, want);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_step_seconds();
        convert_and_check(6'd59, 6'd10, 16'h5910, "step_sec_10");
        convert_and_check(6'd59, 6'd9,  16'h5909, "step_sec_09");
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int overlap = 0;
        logic [15:0] first = 16'h0;
        logic [15:0] second = 16'h0;
        inMinutes = 6'd12; inSeconds = 6'd34;
        repeat (2) @(negedge clk);
        inMinutes = 6'd45; inSeconds = 6'd6;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (update && busy) overlap++;
            if (update) begin
                pulses++;
                if (pulses == 1) first = digits;
                if (pulses == 2) second = digits;
            end
        end
        total++;
        if (pulses != 2) $display("FAIL b2b_pulses: got %0d want 2", pulses);
        else passed++;
        total++;
        if (first !== 16'h1234) $display("FAIL b2b_first: got %h want 1234", first);
        else passed++;
        total++;
        if (second !== 16'h4506) $display("FAIL b2b_second: got %h want 4506", second);
        else passed++;
        total++;
        if (overlap != 0) $display("FAIL b2b_overlap: update and busy together %0d cycles want 0", overlap);
        else passed++;
    endtask

    task automatic test_out_of_range();
        convert_and_check(6'd63, 6'd60, 16'h6360, "range_63_60");
        convert_and_check(6'd0,  6'd7,  16'h0007, "range_00_07");
    endtask

    task automatic test_reset_mid();
        inMinutes = 6'd7; inSeconds = 6'd7;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL mid_busy: got busy=%b want 1", busy);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({digits, valid, update, busy} !== 19'd0)
            $display("FAIL mid_reset: got digits=%h v/u/b=%b%b%b want 0000 000", digits, valid, update, busy);
        else passed++;
        reset = 1'b0;
        convert_and_check(6'd7, 6'd7, 16'h0707, "after_reset_07_07");
    endtask

`ifdef FINISH_BLINK_EN
    task automatic test_blink();
        int bad = 0;
        logic [15:0] want;
        convert_and_check(6'd0, 6'd0, 16'h0000, "blink_setup");
        finish = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            want = (((i + 1) / 4) % 2 == 1) ? 16'hFFFF : 16'h0000;
            if (digits !== want) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL blink_pattern: %0d wrong samples, last digits=%h", bad, digits);
        else passed++;
        repeat (4) @(negedge clk);
        finish = 1'b0;
        @(negedge clk);
        total++;
        if (digits !== 16'h0000) $display("FAIL blink_stop: got %h want 0000", digits);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_first_conversion();
        test_convert_59();
        test_step_seconds();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
`ifdef FINISH_BLINK_EN
        test_blink();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/time_bcd_converter.md
Name: time_bcd_converter

Overview:
- Sits directly downstream of the minutes/seconds countdown counter.
- Takes its 6-bit binary minutes and seconds values and converts them into four BCD digits (MM:SS) for the VGA character renderer.
- Uses a sequential shift-add-3 (double dabble) engine, re-run whenever either input changes.
- Outputs update atomically, with a one-cycle update strobe, so the renderer never sees a half-converted time.

Parameters:
- IN_WIDTH, 6, width of each binary input; legal range 4..6, so every value fits two BCD digits.
- BLINK_PERIOD, 25000000, clock cycles per blink half-period; used only with FINISH_BLINK_EN.
- BLANK_CODE, 4'hF, digit code that tells the renderer to draw a blank cell; used only with FINISH_BLINK_EN.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- inMinutes  input  IN_WIDTH  binary minutes from the counter.
- inSeconds  input  IN_WIDTH  binary seconds from the counter.
- finish  input  1  counter finished flag; used only with FINISH_BLINK_EN.
- minTens  output  4  BCD tens digit of minutes.
- minOnes  output  4  BCD ones digit of minutes.
- secTens  output  4  BCD tens digit of seconds.
- secOnes  output  4  BCD ones digit of seconds.
- valid  output  1  high once the first conversion after reset has completed.
- update  output  1  one-cycle pulse when the digit outputs change.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- One clock: clk. Reset is synchronous and active-high on port reset; it is sampled only on the rising edge of clk.
- Reset values:
  - all four digits = 0; valid = 0; update = 0; busy = 0.
  - FSM = IDLE; primed flag = 0; shadow registers = 0; bit counter = 0; blink counter and blink phase = 0.
- FSM has three states: IDLE, SHIFT, LOAD.
- IDLE:
  - A conversion starts when primed = 0, or when {inMinutes, inSeconds} differs from the shadow registers.
  - On start: copy inputs into the shadow and shift registers, clear both 8-bit BCD scratch registers, set bit count = IN_WIDTH, set busy = 1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one input bit per cycle, minutes and seconds processed in parallel:
  - Correct first: in each scratch nibble, any value >= 5 gets +3.
  - Then shift {scratch, shift reg} left by one.
  - Decrement the bit count; after IN_WIDTH cycles go to LOAD.
- LOAD:
  - Copy the scratch nibbles to the digit outputs; set primed = 1 and valid = 1.
  - update = 1 for exactly the following cycle; busy = 0; go to IDLE.
- Latency: start detected at edge k; outputs valid after edge k+IN_WIDTH+1 (edge k+7 for the default). A new conversion can start at the next edge.
- Input change during SHIFT/LOAD:
  - The running conversion completes using the captured values; inputs are not resampled mid-conversion.
  - The following IDLE cycle sees the mismatch and restarts.
  - Intermediate values may therefore be skipped; the final displayed value always equals the stable input.
- Inputs that hold steady cause no conversions, so update stays 0.
- Out-of-range values 60..63 are converted literally (e.g. 63 -> 6,3); no clamping.
- Reset mid-conversion:
  - Aborts immediately and all outputs return to reset values.
  - The conversion of the current inputs starts on the first edge after reset deasserts.
- update and busy are never high in the same cycle.

Optional Feature:
- Macro: FINISH_BLINK_EN.
- Defined:
  - While finish = 1, a counter toggles the blink phase every BLINK_PERIOD cycles.
  - When the phase is 1, all four digit outputs show BLANK_CODE; conversion and update behaviour are otherwise unchanged.
  - When finish falls, the phase and counter clear on the next edge and the real digits show again.
- Not defined: finish is ignored, and no blink counter is synthesised.

Test Plan:
- Reset released with inputs 0/0 -> busy for 7 cycles, update pulse, digits 0,0,0,0, valid = 1 from then on.
- inMinutes = 59, inSeconds = 59 held -> digits 5,9,5,9 appear 7 edges after the start edge; exactly one update pulse; no further pulses while inputs hold.
- Seconds stepped 10 -> 9 on the tick boundary -> secTens/secOnes go 1,0 -> 0,9; minute digits unchanged.
- Inputs changed from 12:34 to 45:06 two cycles into a conversion -> 12:34 is output first, then a second conversion gives 4,5,0,6; two update pulses in total.
- inMinutes = 63 -> minTens = 6, minOnes = 3. Reset asserted during SHIFT -> next cycle all outputs 0 and valid = 0.
- FINISH_BLINK_EN defined, BLINK_PERIOD = 4, finish = 1 at 00:00 -> digits alternate 0 / 4'hF every 4 cycles; finish = 0 -> steady 0,0,0,0.
